regs_wb_ctrl: RTL and testbench
===============================

Name: regs_wb_ctrl

Overview:
- Write-side controller for the core's 32x32 register file.
- Merges writeback results from the single-cycle execute unit (exe) and the load/store unit (lsu) onto the file's single write port (wen/addr/data), one write per cycle.
- Buffers displaced exe results in a small in-order FIFO and back-pressures exe when that FIFO is full.
- Keeps a pending-write scoreboard so issue logic can stall on RAW hazards.

Parameters:
- BUF_DEPTH, 2, exe result FIFO entries; legal range 1..4.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-low
- exe_valid_in  input  1  exe result valid
- exe_rd_in  input  5  exe destination register
- exe_data_in  input  32  exe result
- exe_ready_out  output  1  exe result accepted this cycle when high with exe_valid_in
- lsu_valid_in  input  1  load result valid; always accepted, no ready
- lsu_rd_in  input  5  load destination register
- lsu_data_in  input  32  load data
- iss_valid_in  input  1  instruction with a register destination issued this cycle
- iss_rd_in  input  5  issued instruction's destination
- rs1_addr_in  input  5  issue-stage source 1 query
- rs2_addr_in  input  5  issue-stage source 2 query
- rs1_busy_out  output  1  source 1 has an outstanding write
- rs2_busy_out  output  1  source 2 has an outstanding write
- pending_mask_out  output  32  scoreboard bit per register; bit 0 always 0
- regs_wen_out  output  1  register file write enable
- regs_write_addr_out  output  5  register file write address
- regs_write_data_out  output  32  register file write data

Behaviour:
- Reset (rst==0 at posedge):
  - FIFO emptied, write stage W cleared, scoreboard cleared.
  - regs_wen_out=0, regs_write_addr_out=0, regs_write_data_out=0, pending_mask_out=0.
  - exe_ready_out is forced 0 while rst is low; busy outputs are 0.
  - Reset mid-operation discards all buffered and in-flight results.
- exe_ready_out = rst && (fifo_count < BUF_DEPTH). It is combinational from registered state only, with no path from exe_valid_in.
- Accept: exe is accepted when exe_valid_in && exe_ready_out; lsu is accepted whenever lsu_valid_in is high.
- x0 results: an accepted result with rd==0 is dropped. It does not enter the FIFO, does not use the write port, and does not change the scoreboard.
- Source select per cycle, priority:
  1. lsu, if valid.
  2. FIFO head, if the FIFO is non-empty.
  3. The accepted exe result directly, if the FIFO is empty.
- The selected result loads W at the next posedge.
- W drives the regs_* outputs directly: one-cycle latency from accept to regs_wen_out. The wen pulse lasts exactly one cycle per result.
- FIFO push: an accepted exe result (rd!=0) is pushed when it is not selected, i.e. when lsu is valid or the FIFO is non-empty. This keeps exe results in order.
- Same-cycle pop and push is allowed, and fifo_count is unchanged. A push on a full FIFO cannot occur because ready is low.
- No source valid: W loads wen=0. addr/data are held at their last values (don't-care).
- Scoreboard:
  - At posedge, pending[iss_rd_in] is set if iss_valid_in && iss_rd_in!=0.
  - pending[regs_write_addr_out] is cleared if regs_wen_out.
  - If set and clear hit the same register in the same cycle, set wins.
- busy: rsN_busy_out = pending[rsN_addr_in] && rsN_addr_in!=0. This is combinational.
- While W holds rd, busy stays high even though the register file bypasses the write data. Consumers stall one extra cycle.
- Issue logic guarantees at most one outstanding write per register (WAW stall on busy rd). Behaviour with duplicates is undefined.

Optional Feature:
- Macro: REGS_WB_FWD_EN.
- Enabled:
  - Adds outputs rs1_fwd_valid_out (1), rs1_fwd_data_out (32), rs2_fwd_valid_out (1) and rs2_fwd_data_out (32).
  - fwd_valid is high when W (wen=1) or any FIFO entry holds rsN_addr_in!=0.
  - The data comes from the youngest match: FIFO tail-most entry first, then W.
  - rsN_busy_out is forced 0 when fwd_valid is high.
- Disabled: these ports are absent, and busy follows only the scoreboard rule above.

Test Plan:
- Reset hold: rst=0 for 3 cycles with all valids high -> regs_wen_out=0, exe_ready_out=0, pending_mask_out=0. The cycle after rst=1, exe_ready_out=1.
- Single exe: exe_valid_in=1, rd=5, data=0xDEADBEEF for one cycle -> next cycle regs_wen_out=1, addr=5, data=0xDEADBEEF; the cycle after, wen=0.
- Collision:
  - lsu (rd=3, 0x11) and exe (rd=4, 0x22) are valid in cycle 0.
  - Cycle 1: write rd3=0x11. Cycle 2: write rd4=0x22.
  - fifo_count is 1 during cycle 1.
- Back-pressure, BUF_DEPTH=2:
  - lsu is valid for 4 cycles with exe valid every cycle (rd 6,7,8).
  - exe_ready_out drops after 2 accepts.
  - After lsu stops, writes follow in order: rd6, rd7, then rd8.
- x0 drop: exe rd=0, data=0x1234 -> regs_wen_out never asserts, FIFO unchanged, exe_ready_out stays 1.
- Scoreboard:
  - iss rd=9 -> pending_mask_out bit 9 = 1; rs1_addr_in=9 gives rs1_busy_out=1.
  - A later exe rd=9 write clears the bit at the edge where wen=1.
  - A simultaneous iss rd=9 on that edge keeps bit 9 set.
  - With REGS_WB_FWD_EN, busy is 0 and rs1_fwd_data_out shows the data while the result sits in W.

Source files
------------

// File: rtl/regs_wb_ctrl_if.sv
// regs_wb_ctrl_if: exe/lsu/issue inputs and register-file write outputs of the writeback controller.
// REGS_WB_FWD_EN adds the source forwarding signals.
interface regs_wb_if;
  logic        exe_valid_in;
  logic [4:0]  exe_rd_in;
  logic [31:0] exe_data_in;
  logic        exe_ready_out;
  logic        lsu_valid_in;
  logic [4:0]  lsu_rd_in;
  logic [31:0] lsu_data_in;
  logic        iss_valid_in;
  logic [4:0]  iss_rd_in;
  logic [4:0]  rs1_addr_in;
  logic [4:0]  rs2_addr_in;
  logic        rs1_busy_out;
  logic        rs2_busy_out;
  logic [31:0] pending_mask_out;
  logic        regs_wen_out;
  logic [4:0]  regs_write_addr_out;
  logic [31:0] regs_write_data_out;
`ifdef REGS_WB_FWD_EN
  logic        rs1_fwd_valid_out;
  logic [31:0] rs1_fwd_data_out;
  logic        rs2_fwd_valid_out;
  logic [31:0] rs2_fwd_data_out;
`endif
  modport master (
    output exe_valid_in, exe_rd_in, exe_data_in, lsu_valid_in, lsu_rd_in, lsu_data_in,
           iss_valid_in, iss_rd_in, rs1_addr_in, rs2_addr_in,
    input  exe_ready_out, rs1_busy_out, rs2_busy_out, pending_mask_out,
           regs_wen_out, regs_write_addr_out, regs_write_data_out
`ifdef REGS_WB_FWD_EN
    , input rs1_fwd_valid_out, rs1_fwd_data_out, rs2_fwd_valid_out, rs2_fwd_data_out
`endif
  );
  modport slave (
    input  exe_valid_in, exe_rd_in, exe_data_in, lsu_valid_in, lsu_rd_in, lsu_data_in,
           iss_valid_in, iss_rd_in, rs1_addr_in, rs2_addr_in,
    output exe_ready_out, rs1_busy_out, rs2_busy_out, pending_mask_out,
           regs_wen_out, regs_write_addr_out, regs_write_data_out
`ifdef REGS_WB_FWD_EN
    , output rs1_fwd_valid_out, rs1_fwd_data_out, rs2_fwd_valid_out, rs2_fwd_data_out
`endif
  );
endinterface

// File: rtl/regs_wb_ctrl.sv
// regs_wb_ctrl: merges exe/lsu writebacks onto one register-file write port, with an exe FIFO and RAW scoreboard.
// REGS_WB_FWD_EN adds forwarding of in-flight results from W and the FIFO.
module regs_wb_ctrl #(
  parameter int BUF_DEPTH = 2
) (
  input logic     clk,
  input logic     rst,
  regs_wb_if.slave wb
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  logic [4:0]    r_fifo_rd   [BUF_DEPTH];
  logic [31:0]   r_fifo_data [BUF_DEPTH];
  logic [CW-1:0] r_count;
  logic          r_wen;
  logic [4:0]    r_addr;
  logic [31:0]   r_data;
  logic [31:0]   r_pending;
  logic          w_lsu_live, w_exe_live, w_fifo_ne, w_pop, w_direct, w_push, w_sel;
  logic [CW-1:0] w_wptr;
  logic [4:0]    w_sel_rd;
  logic [31:0]   w_sel_data, w_set, w_clr;
  assign wb.exe_ready_out = rst && (r_count < CW'(BUF_DEPTH));
  assign w_fifo_ne  = r_count != '0;
  assign w_lsu_live = wb.lsu_valid_in && wb.lsu_rd_in != 5'd0;
  assign w_exe_live = wb.exe_valid_in && wb.exe_ready_out && wb.exe_rd_in != 5'd0;
  assign w_pop      = !w_lsu_live && w_fifo_ne;
  assign w_direct   = !w_lsu_live && !w_fifo_ne && w_exe_live;
  // exe results bypass the FIFO only when nothing older is waiting
  assign w_push     = w_exe_live && (w_lsu_live || w_fifo_ne);
  assign w_sel      = w_lsu_live || w_pop || w_direct;
  assign w_wptr     = r_count - CW'(w_pop);
  assign w_sel_rd   = w_lsu_live ? wb.lsu_rd_in : w_pop ? r_fifo_rd[0] : wb.exe_rd_in;
  assign w_sel_data = w_lsu_live ? wb.lsu_data_in : w_pop ? r_fifo_data[0] : wb.exe_data_in;
  assign w_set      = (wb.iss_valid_in && wb.iss_rd_in != 5'd0) ? (32'd1 << wb.iss_rd_in) : 32'd0;
  assign w_clr      = r_wen ? (32'd1 << r_addr) : 32'd0;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else begin
      if (w_pop)
        for (int i = 0; i < BUF_DEPTH - 1; i++) begin
          r_fifo_rd[i]   <= r_fifo_rd[i+1];
          r_fifo_data[i] <= r_fifo_data[i+1];
        end
      for (int i = 0; i < BUF_DEPTH; i++)
        if (w_push && i == int'(w_wptr)) begin
          r_fifo_rd[i]   <= wb.exe_rd_in;
          r_fifo_data[i] <= wb.exe_data_in;
        end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wen     <= 1'b0;
      r_addr    <= 5'd0;
      r_data    <= 32'd0;
      r_pending <= 32'd0;
    end else begin
      r_wen <= w_sel;
      if (w_sel) begin
        r_addr <= w_sel_rd;
        r_data <= w_sel_data;
      end
      r_pending <= (r_pending & ~w_clr) | w_set;
    end
  end
  assign wb.regs_wen_out        = r_wen;
  assign wb.regs_write_addr_out = r_addr;
  assign wb.regs_write_data_out = r_data;
  assign wb.pending_mask_out    = r_pending;
`ifdef REGS_WB_FWD_EN
  logic [1:0][4:0]  w_q;
  logic [1:0]       w_fv;
  logic [1:0][31:0] w_fd;
  assign w_q[0] = wb.rs1_addr_in;
  assign w_q[1] = wb.rs2_addr_in;
  // W is the oldest in-flight result, later FIFO slots are younger and override it
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      w_fv[s] = r_wen && r_addr == w_q[s] && w_q[s] != 5'd0;
      w_fd[s] = r_data;
      for (int i = 0; i < BUF_DEPTH; i++)
        if (i < int'(r_count) && r_fifo_rd[i] == w_q[s] && w_q[s] != 5'd0) begin
          w_fv[s] = 1'b1;
          w_fd[s] = r_fifo_data[i];
        end
    end
  end
  assign wb.rs1_fwd_valid_out = w_fv[0];
  assign wb.rs1_fwd_data_out  = w_fd[0];
  assign wb.rs2_fwd_valid_out = w_fv[1];
  assign wb.rs2_fwd_data_out  = w_fd[1];
  assign wb.rs1_busy_out = r_pending[wb.rs1_addr_in] && wb.rs1_addr_in != 5'd0 && !w_fv[0];
  assign wb.rs2_busy_out = r_pending[wb.rs2_addr_in] && wb.rs2_addr_in != 5'd0 && !w_fv[1];
`else
  assign wb.rs1_busy_out = r_pending[wb.rs1_addr_in] && wb.rs1_addr_in != 5'd0;
  assign wb.rs2_busy_out = r_pending[wb.rs2_addr_in] && wb.rs2_addr_in != 5'd0;
`endif
endmodule

// File: tb/tb_regs_wb_ctrl.sv
// tb_regs_wb_ctrl: directed vectors with a write-port scoreboard for regs_wb_ctrl.
module tb_regs_wb_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  logic [39:0] exp_q [$];
  regs_wb_if bus();
  regs_wb_ctrl #(.BUF_DEPTH(2)) dut (.clk(clk), .rst(rst), .wb(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  task automatic expw(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({3'b0, a, d});
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    bus.exe_valid_in = 1'b0; bus.exe_rd_in = 5'd0; bus.exe_data_in = 32'd0;
    bus.lsu_valid_in = 1'b0; bus.lsu_rd_in = 5'd0; bus.lsu_data_in = 32'd0;
    bus.iss_valid_in = 1'b0; bus.iss_rd_in = 5'd0;
    bus.rs1_addr_in = 5'd0; bus.rs2_addr_in = 5'd0;
  endtask
  task automatic exe(input logic [4:0] a, input logic [31:0] d);
    bus.exe_valid_in = 1'b1; bus.exe_rd_in = a; bus.exe_data_in = d;
  endtask
  task automatic lsu(input logic [4:0] a, input logic [31:0] d);
    bus.lsu_valid_in = 1'b1; bus.lsu_rd_in = a; bus.lsu_data_in = d;
  endtask
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.regs_wen_out !== 1'b0) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0d data %h wen %b want no write",
                 bus.regs_write_addr_out, bus.regs_write_data_out, bus.regs_wen_out);
      end else begin
        chk("write", {3'b0, bus.regs_write_addr_out, bus.regs_write_data_out}, exp_q.pop_front());
      end
    end
  end
  initial begin
    logic [4:0] bp_rd [3];
    logic       exp_rdy [6];
    int k;
    bp_rd = '{5'd6, 5'd7, 5'd8};
    exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    idle();
    exe(5'd1, 32'h1); lsu(5'd2, 32'h2);
    bus.iss_valid_in = 1'b1; bus.iss_rd_in = 5'd3; bus.rs1_addr_in = 5'd3;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_wen", 40'(bus.regs_wen_out), 40'd0);
      chk("rst_ready", 40'(bus.exe_ready_out), 40'd0);
      chk("rst_mask", 40'(bus.pending_mask_out), 40'd0);
      chk("rst_busy", 40'(bus.rs1_busy_out), 40'd0);
    end
    rst = 1'b1;
    idle();
    tick();
    @(negedge clk);
    chk("post_rst_ready", 40'(bus.exe_ready_out), 40'd1);
    chk("post_rst_wen", 40'(bus.regs_wen_out), 40'd0);
    tick();
    exe(5'd5, 32'hDEADBEEF);
    expw(5'd5, 32'hDEADBEEF);
    @(negedge clk);
    chk("single_ready", 40'(bus.exe_ready_out), 40'd1);
    tick();
    idle();
    @(negedge clk);
    chk("single_wen", 40'(bus.regs_wen_out), 40'd1);
    tick();
    @(negedge clk);
    chk("single_wen_drop", 40'(bus.regs_wen_out), 40'd0);
    tick();
    lsu(5'd3, 32'h11); exe(5'd4, 32'h22);
    expw(5'd3, 32'h11); expw(5'd4, 32'h22);
    tick();
    idle();
    repeat (2) tick();
    expw(5'd10, 32'hA0); expw(5'd11, 32'hA1); expw(5'd12, 32'hA2); expw(5'd13, 32'hA3);
    expw(5'd6, 32'h60); expw(5'd7, 32'h70); expw(5'd8, 32'h80);
    k = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      idle();
      if (c < 4) lsu(5'(10 + c), 32'hA0 + 32'(c));
      if (k < 3) exe(bp_rd[k], {24'd0, bp_rd[k], 3'd0} * 32'd2);
      @(negedge clk);
      chk($sformatf("bp_ready_c%0d", c), 40'(bus.exe_ready_out), 40'(exp_rdy[c]));
      if (exp_rdy[c] && k < 3) k++;
    end
    tick();
    idle();
    repeat (4) tick();
    lsu(5'd15, 32'h55); exe(5'd0, 32'h1234);
    expw(5'd15, 32'h55);
    @(negedge clk);
    chk("x0_ready_a", 40'(bus.exe_ready_out), 40'd1);
    tick();
    idle();
    exe(5'd0, 32'h1234);
    @(negedge clk);
    chk("x0_ready_b", 40'(bus.exe_ready_out), 40'd1);
    tick();
    idle();
    @(negedge clk);
    chk("x0_ready_c", 40'(bus.exe_ready_out), 40'd1);
    repeat (3) tick();
    bus.iss_valid_in = 1'b1; bus.iss_rd_in = 5'd9;
    tick();
    idle();
    bus.rs1_addr_in = 5'd9; bus.rs2_addr_in = 5'd9;
    @(negedge clk);
    chk("sb_mask_set", 40'(bus.pending_mask_out), 40'h200);
    chk("sb_rs1_busy", 40'(bus.rs1_busy_out), 40'd1);
    chk("sb_rs2_busy", 40'(bus.rs2_busy_out), 40'd1);
    tick();
    exe(5'd9, 32'h99);
    expw(5'd9, 32'h99);
    tick();
    bus.exe_valid_in = 1'b0;
    bus.iss_valid_in = 1'b1; bus.iss_rd_in = 5'd9;
    @(negedge clk);
    chk("sb_mask_inW", 40'(bus.pending_mask_out), 40'h200);
`ifdef REGS_WB_FWD_EN
    chk("fwd_busy", 40'(bus.rs1_busy_out), 40'd0);
    chk("fwd_valid", 40'(bus.rs1_fwd_valid_out), 40'd1);
    chk("fwd_data", 40'(bus.rs1_fwd_data_out), 40'h99);
`else
    chk("sb_busy_inW", 40'(bus.rs1_busy_out), 40'd1);
`endif
    tick();
    bus.iss_valid_in = 1'b0;
    @(negedge clk);
    chk("sb_set_wins", 40'(bus.pending_mask_out), 40'h200);
    chk("sb_busy_kept", 40'(bus.rs1_busy_out), 40'd1);
    tick();
    exe(5'd9, 32'h9A);
    expw(5'd9, 32'h9A);
    tick();
    bus.exe_valid_in = 1'b0;
    tick();
    @(negedge clk);
    chk("sb_mask_clr", 40'(bus.pending_mask_out), 40'd0);
    chk("sb_busy_clr", 40'(bus.rs1_busy_out), 40'd0);
    repeat (3) tick();
    @(negedge clk);
    chk("queue_empty", 40'(exp_q.size()), 40'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
